// File: rtl/game_pkg.sv
// game_pkg: lane encoding, tracker states and default game parameters shared by the sequencer and compositor
package game_pkg;
  typedef enum logic [1:0] {
    LANE_NULL  = 2'b00,
    LANE_LEFT  = 2'b01,
    LANE_MID   = 2'b10,
    LANE_RIGHT = 2'b11
  } lane_t;
  typedef enum logic {TRK_IDLE, TRK_FLY} trk_state_t;
  localparam int DEF_START_LIVES     = 3;
  localparam int DEF_APPROACH_FRAMES = 64;
  localparam int DEF_INVULN_FRAMES   = 60;
endpackage

// File: rtl/object_tracker.sv
// object_tracker: release-code change detect, one pending slot, IDLE/FLY flight with Y counter
//   in:  clk, rst, tick (frame tick), code (release lane), halt (game over, forces idle)
//   out: lane (in-flight lane, NULL when idle), y (approach progress), impact (strobe on the final tick)
module object_tracker
  import game_pkg::*;
#(
  parameter int APPROACH_FRAMES = DEF_APPROACH_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  lane_t      code,
  input  logic       halt,
  output lane_t      lane,
  output logic [6:0] y,
  output logic       impact
);
  trk_state_t st_q, st_d;
  lane_t prev_q, prev_d, pend_lane_q, pend_lane_d, lane_q, lane_d;
  logic pend_v_q, pend_v_d;
  logic [6:0] y_q, y_d;
  logic run, chg, launch;
  assign run = tick && !halt;
  assign chg = run && code != LANE_NULL && code != prev_q;
  assign impact = run && st_q == TRK_FLY && y_q == 7'(APPROACH_FRAMES - 1);
  // launch consumes the slot as it stood before this tick; the impact tick never launches
  assign launch = run && st_q == TRK_IDLE && pend_v_q;
  always_comb begin
    prev_d      = run ? code : prev_q;
    pend_v_d    = halt ? 1'b0 : chg ? 1'b1 : launch ? 1'b0 : pend_v_q;
    pend_lane_d = chg ? code : pend_lane_q;
    st_d        = (halt || impact) ? TRK_IDLE : launch ? TRK_FLY : st_q;
    lane_d      = (halt || impact) ? LANE_NULL : launch ? pend_lane_q : lane_q;
    y_d         = (halt || impact || launch) ? 7'd0 : (run && st_q == TRK_FLY) ? y_q + 7'd1 : y_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= TRK_IDLE;
      prev_q      <= LANE_NULL;
      pend_v_q    <= 1'b0;
      pend_lane_q <= LANE_NULL;
      lane_q      <= LANE_NULL;
      y_q         <= 7'd0;
    end else begin
      st_q        <= st_d;
      prev_q      <= prev_d;
      pend_v_q    <= pend_v_d;
      pend_lane_q <= pend_lane_d;
      lane_q      <= lane_d;
      y_q         <= y_d;
    end
  end
  assign lane = lane_q;
  assign y = y_q;
endmodule

// File: rtl/life_compositor.sv
// life_compositor: launches coin/barrier objects, resolves impacts against the player, keeps lives/invuln/coins
//   in:  i_clk, i_rst, i_v_sync (frame strobe), GAME_SWITCH, RELEASE_COIN/BARRIER, PLAYER_LANE, PLAYER_JUMP
//   out: ZERO_LIVES, LIVES, COINS, COIN/BARRIER_LANE, COIN/BARRIER_Y, HIT_FLASH
module life_compositor
  import game_pkg::*;
#(
  parameter int START_LIVES     = DEF_START_LIVES,
  parameter int APPROACH_FRAMES = DEF_APPROACH_FRAMES,
  parameter int INVULN_FRAMES   = DEF_INVULN_FRAMES
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_v_sync,
  input  logic       GAME_SWITCH,
  input  logic [1:0] RELEASE_COIN,
  input  logic [1:0] RELEASE_BARRIER,
  input  logic [1:0] PLAYER_LANE,
  input  logic       PLAYER_JUMP,
  output logic       ZERO_LIVES,
  output logic [1:0] LIVES,
  output logic [7:0] COINS,
  output logic [1:0] COIN_LANE,
  output logic [1:0] BARRIER_LANE,
  output logic [6:0] COIN_Y,
  output logic [6:0] BARRIER_Y,
  output logic       HIT_FLASH
);
  logic v_d_q, tick, zero, c_imp, b_imp, c_hit, b_hit, on_lane_c, on_lane_b;
  logic [1:0] lives_q, lives_d;
  logic [7:0] invuln_q, invuln_d, coins_q, coins_d;
  lane_t c_lane, b_lane;
  assign tick = i_v_sync & ~v_d_q & GAME_SWITCH;
  assign zero = lives_q == 2'd0;
  object_tracker #(.APPROACH_FRAMES(APPROACH_FRAMES)) u_coin (
    .clk(i_clk), .rst(i_rst), .tick(tick), .code(lane_t'(RELEASE_COIN)), .halt(zero),
    .lane(c_lane), .y(COIN_Y), .impact(c_imp)
  );
  object_tracker #(.APPROACH_FRAMES(APPROACH_FRAMES)) u_barrier (
    .clk(i_clk), .rst(i_rst), .tick(tick), .code(lane_t'(RELEASE_BARRIER)), .halt(zero),
    .lane(b_lane), .y(BARRIER_Y), .impact(b_imp)
  );
  assign on_lane_c = PLAYER_LANE != 2'b00 && lane_t'(PLAYER_LANE) == c_lane;
  assign on_lane_b = PLAYER_LANE != 2'b00 && lane_t'(PLAYER_LANE) == b_lane;
  assign c_hit = c_imp && on_lane_c;
  assign b_hit = b_imp && on_lane_b && !PLAYER_JUMP && invuln_q == 8'd0 && !zero;
  always_comb begin
    lives_d  = b_hit ? lives_q - 2'd1 : lives_q;
    invuln_d = b_hit ? 8'(INVULN_FRAMES) : (tick && !zero && invuln_q != 8'd0) ? invuln_q - 8'd1 : invuln_q;
    coins_d  = (c_hit && coins_q != 8'hff) ? coins_q + 8'd1 : coins_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v_d_q    <= 1'b0;
      lives_q  <= 2'(START_LIVES);
      invuln_q <= 8'd0;
      coins_q  <= 8'd0;
    end else begin
      v_d_q    <= i_v_sync;
      lives_q  <= lives_d;
      invuln_q <= invuln_d;
      coins_q  <= coins_d;
    end
  end
  assign ZERO_LIVES   = zero;
  assign LIVES        = lives_q;
  assign COINS        = coins_q;
  assign COIN_LANE    = c_lane;
  assign BARRIER_LANE = b_lane;
  assign HIT_FLASH    = invuln_q != 8'd0;
endmodule

// File: tb/tb_life_compositor.sv
// tb_life_compositor: directed and randomized frames checked each cycle against a frame-level game model
module tb_life_compositor;
  localparam int A = 64;
  localparam int INV = 60;
  localparam int SL = 3;
  logic clk = 1'b0;
  logic rst, vs, gs, pj;
  logic [1:0] rc, rb, pl;
  logic zl, hf;
  logic [1:0] lives, cl, bl;
  logic [7:0] coins;
  logic [6:0] cy, by;
  always #5 clk = ~clk;
  life_compositor #(.START_LIVES(SL), .APPROACH_FRAMES(A), .INVULN_FRAMES(INV)) dut (
    .i_clk(clk), .i_rst(rst), .i_v_sync(vs), .GAME_SWITCH(gs),
    .RELEASE_COIN(rc), .RELEASE_BARRIER(rb), .PLAYER_LANE(pl), .PLAYER_JUMP(pj),
    .ZERO_LIVES(zl), .LIVES(lives), .COINS(coins), .COIN_LANE(cl), .BARRIER_LANE(bl),
    .COIN_Y(cy), .BARRIER_Y(by), .HIT_FLASH(hf)
  );
  int tests = 0, fails = 0;
  int m_vd, m_lives, m_inv, m_coins;
  int c_prev[2], c_pend[2], c_fly[2], c_lane[2], c_age[2];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic clear_objects();
    for (int c = 0; c < 2; c++) begin
      c_pend[c] = -1; c_fly[c] = 0; c_lane[c] = 0; c_age[c] = 0;
    end
  endtask
  task automatic step();
    int code[2];
    int imp[2], il[2];
    bit tk, bh, ch;
    code[0] = rc; code[1] = rb;
    tk = vs && !m_vd && gs;
    m_vd = vs;
    if (rst) begin
      m_vd = 0; m_lives = SL; m_inv = 0; m_coins = 0;
      clear_objects();
      c_prev[0] = 0; c_prev[1] = 0;
    end else if (m_lives == 0) begin
      clear_objects();
    end else if (tk) begin
      for (int c = 0; c < 2; c++) begin
        imp[c] = 0; il[c] = c_lane[c];
        if (c_fly[c] && c_age[c] == A - 1) begin
          imp[c] = 1; c_fly[c] = 0; c_lane[c] = 0; c_age[c] = 0;
        end else if (c_fly[c]) c_age[c]++;
        else if (c_pend[c] >= 0) begin
          c_fly[c] = 1; c_lane[c] = c_pend[c]; c_age[c] = 0; c_pend[c] = -1;
        end
        if (code[c] != 0 && code[c] != c_prev[c]) c_pend[c] = code[c];
        c_prev[c] = code[c];
      end
      ch = imp[0] && pl != 0 && il[0] == pl;
      bh = imp[1] && pl != 0 && il[1] == pl && !pj && m_inv == 0;
      m_inv = bh ? INV : (m_inv > 0 ? m_inv - 1 : 0);
      if (bh) m_lives--;
      if (ch && m_coins < 255) m_coins++;
    end
    @(posedge clk);
    #1;
    check("zero_lives", zl, m_lives == 0);
    check("lives", lives, m_lives);
    check("coins", coins, m_coins);
    check("coin_lane", cl, c_lane[0]);
    check("barrier_lane", bl, c_lane[1]);
    check("coin_y", cy, c_age[0]);
    check("barrier_y", by, c_age[1]);
    check("hit_flash", hf, m_inv > 0);
  endtask
  task automatic frames(input int n, input bit follow_c, input bit follow_b);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        vs = (k == 0);
        if (follow_c) pl = cl;
        if (follow_b) pl = bl;
        step();
      end
    end
  endtask
  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask
  initial begin
    logic [6:0] y_hold;
    rst = 1'b1; vs = 1'b0; gs = 1'b1; rc = 2'b00; rb = 2'b00; pl = 2'b00; pj = 1'b0;
    do_reset();
    rb = 2'b10; pl = 2'b10;
    frames(A + 4, 0, 0);
    check("barrier_hit_lives", lives, 2);
    check("barrier_hit_flash", hf, 1);
    rb = 2'b00;
    frames(INV + 2, 0, 0);
    check("flash_expired", hf, 0);
    do_reset();
    rb = 2'b10; pl = 2'b10; pj = 1'b1;
    frames(A + 4, 0, 0);
    check("jump_lives", lives, 3);
    check("jump_flash", hf, 0);
    pj = 1'b0; rb = 2'b00;
    do_reset();
    rc = 2'b11; frames(70, 1, 0);
    rc = 2'b01; frames(70, 1, 0);
    rc = 2'b00; frames(70, 1, 0);
    rc = 2'b11; frames(70, 1, 0);
    frames(10, 1, 0);
    check("coin_seq", coins, 3);
    rc = 2'b00;
    do_reset();
    rb = 2'b01; frames(70, 0, 1);
    rb = 2'b10; frames(70, 0, 1);
    rb = 2'b11; frames(70, 0, 1);
    rb = 2'b00; frames(3, 0, 1);
    check("game_over", zl, 1);
    check("game_over_lives", lives, 0);
    rc = 2'b01; pl = 2'b01; frames(10, 0, 0);
    rc = 2'b10; pl = 2'b10; frames(A + 4, 0, 0);
    check("frozen_coins", coins, 0);
    check("frozen_lane", cl, 0);
    do_reset();
    rc = 2'b10; frames(20, 0, 0);
    y_hold = cy;
    gs = 1'b0; frames(15, 0, 0);
    check("pause_y", cy, y_hold);
    vs = 1'b1; step(); gs = 1'b1; step(); step(); vs = 1'b0; step();
    check("no_tick_on_enable", cy, y_hold);
    frames(10, 0, 0);
    rst = 1'b1; step(); rst = 1'b0;
    check("reset_lane", cl, 0);
    check("reset_lives", lives, SL);
    do_reset();
    for (int f = 0; f < 700; f++) begin
      if ($urandom_range(0, 9) == 0) rc = 2'($urandom);
      if ($urandom_range(0, 11) == 0) rb = 2'($urandom);
      gs = $urandom_range(0, 9) != 0;
      for (int k = 0; k < 4; k++) begin
        vs = (k == 0) || (k == 1 && $urandom_range(0, 3) == 0);
        pl = 2'($urandom);
        pj = $urandom_range(0, 3) == 0;
        if ($urandom_range(0, 2999) == 0) rst = 1'b1;
        step();
        rst = 1'b0;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
